// File: rtl/tlcd_update_arbiter_if.sv
// ---------------------------------------------------------------------------
// tlcd_update_arbiter_if
//   Bundle between the LCD update arbiter and its requesters / LCD controller.
//   master : requester side (drives REQ and REQ_TEXT, observes everything else)
//   slave  : arbiter side
//   REQ            level request per requester
//   REQ_TEXT       frame i at [i*256 +: 256], upper line in the top 128 bits
//   GNT / DONE     one-hot single-cycle pulses (frame latched / window ended)
//   BUSY           arbiter is in an update or refresh pass
//   OWNER          index of the last granted requester
//   LCD_ENABLE     start strobe towards the text-LCD controller
//   LCD_TEXT_*     latched frame towards the text-LCD controller
// ---------------------------------------------------------------------------
interface tlcd_update_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]     REQ;
    logic [N_REQ*256-1:0] REQ_TEXT;
    logic [N_REQ-1:0]     GNT;
    logic [N_REQ-1:0]     DONE;
    logic                 BUSY;
    logic [OWN_W-1:0]     OWNER;
    logic                 LCD_ENABLE;
    logic [127:0]         LCD_TEXT_UPPER;
    logic [127:0]         LCD_TEXT_LOWER;

    modport master (
        output REQ, REQ_TEXT,
        input  GNT, DONE, BUSY, OWNER, LCD_ENABLE, LCD_TEXT_UPPER, LCD_TEXT_LOWER
    );

    modport slave (
        input  REQ, REQ_TEXT,
        output GNT, DONE, BUSY, OWNER, LCD_ENABLE, LCD_TEXT_UPPER, LCD_TEXT_LOWER
    );
endinterface

// File: rtl/tlcd_update_arbiter.sv
// ---------------------------------------------------------------------------
// tlcd_update_arbiter
//   Shares one text-LCD write controller among N_REQ requesters. A round-robin
//   winner's 2x16 frame is latched, LCD_ENABLE is pulsed for ENABLE_HIGH
//   cycles, and further starts are held off until UPDATE_CYCLES after the
//   enable rise. With REFRESH_CYCLES != 0 the last frame is re-written after
//   that many idle cycles.
// Ports
//   CLK     system clock
//   RESETN  synchronous active-low reset
//   bus     tlcd_update_arbiter_if.slave (REQ/REQ_TEXT in; GNT, DONE, BUSY,
//           OWNER, LCD_ENABLE, LCD_TEXT_UPPER/LOWER out, all registered)
// ---------------------------------------------------------------------------
module tlcd_update_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ENABLE_HIGH    = 4,
    parameter int UPDATE_CYCLES  = 256,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    tlcd_update_arbiter_if.slave bus
);
    localparam int               OWN_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0]      CNT_EN_LAST  = 16'(ENABLE_HIGH);
    localparam logic [15:0]      CNT_END      = 16'(UPDATE_CYCLES);
    localparam logic             REFRESH_ON   = (REFRESH_CYCLES != 0);
    localparam logic [31:0]      REFRESH_LAST = REFRESH_ON ? 32'(REFRESH_CYCLES - 1) : 32'd0;
    localparam logic [31:0]      TIMER_MAX    = 32'hFFFF_FFFF;
    // Pointer starts at the last index so requester 0 wins first after reset.
    localparam logic [OWN_W-1:0] PTR_RESET    = OWN_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // First set request scanning upward from last+1 with wrap.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [OWN_W-1:0] last);
        logic [OWN_W-1:0] pick;
        logic             found;
        logic [OWN_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = OWN_W'((int'(last) + k) % N_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [OWN_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [15:0]       cnt_r, cnt_nxt_s;
    logic [31:0]       timer_r, timer_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic              refresh_r, refresh_nxt_s;
    logic [OWN_W-1:0]  ptr_r, ptr_nxt_s;
    logic [OWN_W-1:0]  owner_r, owner_nxt_s;
    logic [OWN_W-1:0]  win_s;
    logic [N_REQ-1:0]  gnt_r, gnt_nxt_s;
    logic [N_REQ-1:0]  done_r, done_nxt_s;
    logic              busy_r;
    logic              lcd_en_r, lcd_en_nxt_s;
    logic [127:0]      upper_r, upper_nxt_s;
    logic [127:0]      lower_r, lower_nxt_s;
    logic [255:0]      frame_s;
    logic              req_any_s;
    logic              refresh_hit_s;

    assign req_any_s     = |bus.REQ;
    assign win_s         = rr_pick(bus.REQ, ptr_r);
    assign refresh_hit_s = REFRESH_ON && valid_r && (timer_r == REFRESH_LAST);

    // Frame mux for the round-robin winner.
    always_comb begin
        frame_s = 256'd0;
        for (int i = 0; i < N_REQ; i++) begin
            frame_s = frame_s | ({256{win_s == OWN_W'(i)}} & bus.REQ_TEXT[i*256 +: 256]);
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a pending request always beats a refresh expiry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = (req_any_s || refresh_hit_s) ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_nxt_s = ST_PULSE;
            ST_PULSE: state_nxt_s = (cnt_r == CNT_EN_LAST) ? ST_HOLD : ST_PULSE;
            ST_HOLD:  state_nxt_s = (cnt_r == CNT_END) ? ST_IDLE : ST_HOLD;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        timer_nxt_s   = timer_r;
        valid_nxt_s   = valid_r;
        refresh_nxt_s = refresh_r;
        ptr_nxt_s     = ptr_r;
        owner_nxt_s   = owner_r;
        gnt_nxt_s     = '0;
        done_nxt_s    = '0;
        lcd_en_nxt_s  = lcd_en_r;
        upper_nxt_s   = upper_r;
        lower_nxt_s   = lower_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    gnt_nxt_s     = one_hot(win_s);
                    owner_nxt_s   = win_s;
                    ptr_nxt_s     = win_s;
                    upper_nxt_s   = frame_s[255:128];
                    lower_nxt_s   = frame_s[127:0];
                    valid_nxt_s   = 1'b1;
                    refresh_nxt_s = 1'b0;
                    timer_nxt_s   = 32'd0;
                end else if (refresh_hit_s) begin
                    refresh_nxt_s = 1'b1;
                    timer_nxt_s   = 32'd0;
                end else if (timer_r != TIMER_MAX) begin
                    timer_nxt_s   = timer_r + 32'd1;
                end else begin
                    timer_nxt_s   = timer_r;
                end
            end
            ST_SETUP: begin
                lcd_en_nxt_s = 1'b1;
                cnt_nxt_s    = 16'd1;
            end
            ST_PULSE: begin
                cnt_nxt_s    = cnt_r + 16'd1;
                lcd_en_nxt_s = (cnt_r != CNT_EN_LAST);
            end
            ST_HOLD: begin
                cnt_nxt_s = cnt_r + 16'd1;
                // Refresh passes are invisible to requesters: no DONE.
                if ((cnt_r == CNT_END) && !refresh_r) begin
                    done_nxt_s = one_hot(owner_r);
                end else begin
                    done_nxt_s = '0;
                end
            end
            default: begin
                lcd_en_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt_r     <= 16'd0;
            timer_r   <= 32'd0;
            valid_r   <= 1'b0;
            refresh_r <= 1'b0;
            ptr_r     <= PTR_RESET;
            owner_r   <= '0;
            gnt_r     <= '0;
            done_r    <= '0;
            busy_r    <= 1'b0;
            lcd_en_r  <= 1'b0;
            upper_r   <= 128'd0;
            lower_r   <= 128'd0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            timer_r   <= timer_nxt_s;
            valid_r   <= valid_nxt_s;
            refresh_r <= refresh_nxt_s;
            ptr_r     <= ptr_nxt_s;
            owner_r   <= owner_nxt_s;
            gnt_r     <= gnt_nxt_s;
            done_r    <= done_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            lcd_en_r  <= lcd_en_nxt_s;
            upper_r   <= upper_nxt_s;
            lower_r   <= lower_nxt_s;
        end
    end

    assign bus.GNT            = gnt_r;
    assign bus.DONE           = done_r;
    assign bus.BUSY           = busy_r;
    assign bus.OWNER          = owner_r;
    assign bus.LCD_ENABLE     = lcd_en_r;
    assign bus.LCD_TEXT_UPPER = upper_r;
    assign bus.LCD_TEXT_LOWER = lower_r;

endmodule
